mc_ctrl_fsm_hs: RTL
===================

// Module: mc_ctrl_fsm_hs
// PURPOSE
//  Multi-cycle MIPS32 control FSM: sequences fetch/decode/execute/memory/writeback and drives datapath mux selects and write enables.
//  Adds over the fixed-latency controller: sync reset, mem_ready wait states, four branch conditions, sra, overflow trap, illegal-opcode trap, halt.
//  Sits between instruction register (opcode/func) and multi-cycle datapath; memory may insert wait states.
// PARAMETERS
//  ALUOP_W    4  ALUOp width, >=4; bits above [3:0] driven 0
//  MEM_HS     1  1: FETCH/MEM_RD/MEM_WR hold until mem_ready; 0: mem_ready ignored, single cycle
//  TRAP_EN    1  1: overflow/illegal opcode enter TRAP; 0: overflow ignored (result written), illegal -> FETCH
// PORTS
//  clk         in   1  clock, all state on rising edge
//  rst_n       in   1  synchronous active-low reset
//  opcode      in   6  IR[31:26]
//  func        in   6  IR[5:0]
//  Overflow    in   1  ALU signed overflow, valid in exec states
//  mem_ready   in   1  memory access completes this cycle
//  IorD,IRWr,PCWr,PCWrCond,RegDst,RegWr,ALUSrcA,MemWr,MemRd,MemtoReg  out 1 each  datapath controls
//  PCSrc       out  2  00 ALU, 01 ALUOut (branch target), 10 jump target
//  ALUSrcB     out  2  00 B, 01 const 4, 10 signext imm, 11 imm<<2
//  ALUOp       out  ALUOP_W  ALU function
//  BrCond      out  2  00 beq(==), 01 bne(!=), 10 bgtz(>0), 11 blez(<=0); datapath qualifies PCWrCond
//  halted      out  1  high while in HALT
//  trap        out  1  one-cycle pulse on TRAP entry
//  instr_done  out  1  one-cycle pulse in last state of each retired instruction
//  state_out   out  4  current state code
// BEHAVIOUR
//  States(code): FETCH0 DECODE1 MEM_ADDR2 MEM_RD3 MEM_WB4 MEM_WR5 R_EXEC6 R_WB7 BRANCH8 JUMP9 I_WB10 HALT11 TRAP12 RST15.
//  rst_n=0 at edge -> RST. In RST all outputs 0 (ALUOp, PCSrc, ALUSrcB, BrCond = 0). RST -> FETCH next cycle unconditionally.
//  Outputs are decoded combinationally from state (plus opcode/func/mem_ready where noted); unlisted controls are 0.
//  FETCH: MemRd=1, IRWr=PCWr=mem_ready (MEM_HS=1) else 1, ALUSrcB=01, ALUOp=0100; -> DECODE when ready, else stay.
//  DECODE: ALUSrcB=11, ALUOp=0100. R(000000)->R_EXEC; lw,sw,addi,addiu,andi,ori,xori,lui->MEM_ADDR; beq,bne,bgtz,blez->BRANCH;
//   j->JUMP; halt(111111)->HALT; other -> TRAP if TRAP_EN else FETCH.
//  MEM_ADDR: ALUSrcA=1, ALUSrcB=10; ALUOp lw/sw/addi 0100, addiu 0101, andi 0000, ori 0001, xori 0010, lui 1001.
//   -> MEM_RD (lw), MEM_WR (sw), I_WB (others).
//  MEM_RD: IorD=1, MemRd=1; -> MEM_WB when ready. MEM_WB: MemtoReg=1, RegWr=1, instr_done=1; -> FETCH.
//  MEM_WR: IorD=1, MemWr=1 held through wait; -> FETCH when ready, instr_done=1 on that cycle.
//  R_EXEC: ALUSrcA=1, ALUSrcB=00; func add0100 addu0101 sub0110 subu0111 and0000 or0001 xor0010 nor0011 slt1000 sll1010 srl1011 sra1101.
//   Unknown func -> TRAP if TRAP_EN, else ALUOp=0000 and proceed to R_WB.
//  ovf_q: registered; loaded with Overflow at exit of R_EXEC (add/sub only) and MEM_ADDR (addi only); else cleared.
//  R_WB: RegDst=1; I_WB: RegDst=0. Both: RegWr = ~(ovf_q & TRAP_EN); ovf_q&TRAP_EN -> TRAP, else instr_done=1 -> FETCH.
//  BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=1100, PCWrCond=1, PCSrc=01, BrCond per opcode; instr_done=1; -> FETCH.
//  JUMP: PCWr=1, PCSrc=10, instr_done=1; -> FETCH.
//  HALT: halted=1, all enables 0; stays until rst_n=0. TRAP: trap=1 in entry cycle only, enables 0; stays until reset.
//  No write enable (PCWr, IRWr, RegWr, MemWr) ever asserted in RST, HALT, TRAP, or a stalled FETCH/MEM_RD cycle.
//  Reset beats every transition, including mid-wait and HALT/TRAP; MemWr drops in the reset cycle.
// TESTING
//  1 Reset: rst_n=0 2 cycles -> state_out=15, all outputs 0; release -> FETCH, MemRd=1, ALUOp=0100 next cycle.
//  2 lw, mem_ready low 3 cycles in FETCH and MEM_RD -> FETCH x4, DECODE, MEM_ADDR, MEM_RD x4, MEM_WB (RegWr=MemtoReg=1); IRWr/PCWr exactly 1 cycle.
//  3 R add func=100000, Overflow=1 in R_EXEC, TRAP_EN=1 -> R_WB RegWr=0, TRAP, trap 1-cycle pulse; TRAP_EN=0 -> RegWr=1, FETCH.
//  4 bne/bgtz/blez/beq -> BRANCH with BrCond 01/10/11/00, PCSrc=01, PCWrCond=1, 3 cycles total with mem_ready=1.
//  5 sra func=000011 -> ALUOp=1101; illegal opcode 110011 -> TRAP (TRAP_EN=1) or FETCH (TRAP_EN=0).
//  6 sw with rst_n=0 during MEM_WR wait -> MemWr=0 next cycle, state 15; halt opcode -> halted=1 held 10 cycles, instr_done silent.

Source files
------------

// File: rtl/mc_ctrl_fsm_hs_if.sv
// rtl/mc_ctrl_fsm_hs_if.sv - instruction/memory inputs and datapath controls of the multi-cycle controller
interface mc_ctrl_fsm_hs_if #(
  parameter int ALUOP_W = 4
);
  logic [5:0]         opcode;
  logic [5:0]         func;
  logic               Overflow;
  logic               mem_ready;
  logic               IorD;
  logic               IRWr;
  logic               PCWr;
  logic               PCWrCond;
  logic               RegDst;
  logic               RegWr;
  logic               ALUSrcA;
  logic               MemWr;
  logic               MemRd;
  logic               MemtoReg;
  logic [1:0]         PCSrc;
  logic [1:0]         ALUSrcB;
  logic [ALUOP_W-1:0] ALUOp;
  logic [1:0]         BrCond;
  logic               halted;
  logic               trap;
  logic               instr_done;
  logic [3:0]         state_out;

  modport master (
    input  opcode, func, Overflow, mem_ready,
    output IorD, IRWr, PCWr, PCWrCond, RegDst, RegWr, ALUSrcA, MemWr, MemRd, MemtoReg,
    output PCSrc, ALUSrcB, ALUOp, BrCond, halted, trap, instr_done, state_out
  );

  modport slave (
    output opcode, func, Overflow, mem_ready,
    input  IorD, IRWr, PCWr, PCWrCond, RegDst, RegWr, ALUSrcA, MemWr, MemRd, MemtoReg,
    input  PCSrc, ALUSrcB, ALUOp, BrCond, halted, trap, instr_done, state_out
  );
endinterface

// File: rtl/mc_ctrl_fsm_hs.sv
// rtl/mc_ctrl_fsm_hs.sv - multi-cycle MIPS32 control FSM with memory wait states and traps
module mc_ctrl_fsm_hs #(
  parameter int ALUOP_W = 4,
  parameter int MEM_HS  = 1,
  parameter int TRAP_EN = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  mc_ctrl_fsm_hs_if.master bus
);
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXEC   = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_I_WB     = 4'd10,
    S_HALT     = 4'd11,
    S_TRAP     = 4'd12,
    S_RST      = 4'd15
  } state_t;

  localparam logic [5:0] OP_R     = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_BLEZ  = 6'h06;
  localparam logic [5:0] OP_BGTZ  = 6'h07;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_HALT  = 6'h3F;
  localparam bit         TE       = (TRAP_EN != 0);

  state_t     state_q, state_d;
  logic       ovf_q, ovf_d;
  logic       trap_new_q;
  logic       ready;
  logic       r_ok, r_arith;
  logic [3:0] r_op, i_op;

  logic       iord, irwr, pcwr, pcwrcond, regdst, regwr, alusrca, memwr, memrd, memtoreg;
  logic [1:0] pcsrc, alusrcb, brcond;
  logic [3:0] alu_op;
  logic       done;

  assign ready = (MEM_HS == 0) ? 1'b1 : bus.mem_ready;

  always_comb begin
    r_ok    = 1'b1;
    r_arith = 1'b0;
    r_op    = 4'b0000;
    case (bus.func)
      6'h20: begin r_op = 4'b0100; r_arith = 1'b1; end
      6'h21: r_op = 4'b0101;
      6'h22: begin r_op = 4'b0110; r_arith = 1'b1; end
      6'h23: r_op = 4'b0111;
      6'h24: r_op = 4'b0000;
      6'h25: r_op = 4'b0001;
      6'h26: r_op = 4'b0010;
      6'h27: r_op = 4'b0011;
      6'h2A: r_op = 4'b1000;
      6'h00: r_op = 4'b1010;
      6'h02: r_op = 4'b1011;
      6'h03: r_op = 4'b1101;
      default: r_ok = 1'b0;
    endcase
  end

  always_comb begin
    i_op = 4'b0100;
    case (bus.opcode)
      OP_ADDIU: i_op = 4'b0101;
      OP_ANDI:  i_op = 4'b0000;
      OP_ORI:   i_op = 4'b0001;
      OP_XORI:  i_op = 4'b0010;
      OP_LUI:   i_op = 4'b1001;
      default:  i_op = 4'b0100;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_RST;
      ovf_q      <= 1'b0;
      trap_new_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ovf_q      <= ovf_d;
      trap_new_q <= (state_d == S_TRAP) && (state_q != S_TRAP);
    end
  end

  always_comb begin
    state_d  = state_q;
    ovf_d    = 1'b0;
    iord     = 1'b0;
    irwr     = 1'b0;
    pcwr     = 1'b0;
    pcwrcond = 1'b0;
    regdst   = 1'b0;
    regwr    = 1'b0;
    alusrca  = 1'b0;
    memwr    = 1'b0;
    memrd    = 1'b0;
    memtoreg = 1'b0;
    pcsrc    = 2'b00;
    alusrcb  = 2'b00;
    brcond   = 2'b00;
    alu_op   = 4'b0000;
    done     = 1'b0;
    case (state_q)
      S_FETCH: begin
        memrd   = 1'b1;
        irwr    = ready;
        pcwr    = ready;
        alusrcb = 2'b01;
        alu_op  = 4'b0100;
        if (ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        alu_op  = 4'b0100;
        case (bus.opcode)
          OP_R: state_d = S_R_EXEC;
          OP_LW, OP_SW, OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: state_d = S_MEM_ADDR;
          OP_BEQ, OP_BNE, OP_BGTZ, OP_BLEZ: state_d = S_BRANCH;
          OP_J:    state_d = S_JUMP;
          OP_HALT: state_d = S_HALT;
          default: state_d = TE ? S_TRAP : S_FETCH;
        endcase
      end
      S_MEM_ADDR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        alu_op  = i_op;
        ovf_d   = bus.Overflow && (bus.opcode == OP_ADDI);
        if (bus.opcode == OP_LW)      state_d = S_MEM_RD;
        else if (bus.opcode == OP_SW) state_d = S_MEM_WR;
        else                          state_d = S_I_WB;
      end
      S_MEM_RD: begin
        iord  = 1'b1;
        memrd = 1'b1;
        if (ready) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        memtoreg = 1'b1;
        regwr    = 1'b1;
        done     = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEM_WR: begin
        iord  = 1'b1;
        memwr = 1'b1;
        if (ready) begin
          done    = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_R_EXEC: begin
        alusrca = 1'b1;
        alu_op  = r_ok ? r_op : 4'b0000;
        ovf_d   = bus.Overflow && r_arith;
        state_d = (!r_ok && TE) ? S_TRAP : S_R_WB;
      end
      S_R_WB, S_I_WB: begin
        // An overflowing add/sub/addi must not reach the register file when traps are on
        regdst = (state_q == S_R_WB);
        regwr  = !(ovf_q && TE);
        if (ovf_q && TE) begin
          state_d = S_TRAP;
        end else begin
          done    = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_BRANCH: begin
        alusrca  = 1'b1;
        alu_op   = 4'b1100;
        pcwrcond = 1'b1;
        pcsrc    = 2'b01;
        case (bus.opcode)
          OP_BNE:  brcond = 2'b01;
          OP_BGTZ: brcond = 2'b10;
          OP_BLEZ: brcond = 2'b11;
          default: brcond = 2'b00;
        endcase
        done    = 1'b1;
        state_d = S_FETCH;
      end
      S_JUMP: begin
        pcwr    = 1'b1;
        pcsrc   = 2'b10;
        done    = 1'b1;
        state_d = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      S_TRAP:  state_d = S_TRAP;
      S_RST:   state_d = S_FETCH;
      default: state_d = S_RST;
    endcase
  end

  assign bus.IorD       = iord;
  assign bus.IRWr       = irwr;
  assign bus.PCWr       = pcwr;
  assign bus.PCWrCond   = pcwrcond;
  assign bus.RegDst     = regdst;
  assign bus.RegWr      = regwr;
  assign bus.ALUSrcA    = alusrca;
  assign bus.MemWr      = memwr;
  assign bus.MemRd      = memrd;
  assign bus.MemtoReg   = memtoreg;
  assign bus.PCSrc      = pcsrc;
  assign bus.ALUSrcB    = alusrcb;
  assign bus.ALUOp      = ALUOP_W'(alu_op);
  assign bus.BrCond     = brcond;
  assign bus.halted     = (state_q == S_HALT);
  assign bus.trap       = (state_q == S_TRAP) && trap_new_q;
  assign bus.instr_done = done;
  assign bus.state_out  = state_q;
endmodule
